// File: rtl/fir_tap_feeder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fir_tap_feeder_if                                               |
// | Brief    : Sample stream, coefficient load and tap-bus bundle for the      |
// |            FIR tap feeder.                                                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface fir_tap_feeder_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int COEFF_WIDTH  = 8,
  parameter int NUM_TAPS     = 37,
  parameter int ADDR_WIDTH   = $clog2(NUM_TAPS)
);
  logic                           s_valid;
  logic                           s_ready;
  logic signed [SAMPLE_WIDTH-1:0] s_data;
  logic                           flush;
  logic                           coef_we;
  logic        [ADDR_WIDTH-1:0]   coef_addr;
  logic signed [COEFF_WIDTH-1:0]  coef_wdata;
  logic                           coef_commit;
  logic                           coef_pending;
  logic signed [SAMPLE_WIDTH-1:0] samples [0:NUM_TAPS-1];
  logic signed [COEFF_WIDTH-1:0]  coeffs  [0:NUM_TAPS-1];
  logic                           valid_out;

  modport master (
    output s_valid, s_data, flush, coef_we, coef_addr, coef_wdata, coef_commit,
    input  s_ready, coef_pending, samples, coeffs, valid_out
  );

  modport slave (
    input  s_valid, s_data, flush, coef_we, coef_addr, coef_wdata, coef_commit,
    output s_ready, coef_pending, samples, coeffs, valid_out
  );
endinterface
`default_nettype wire

// File: rtl/fir_tap_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fir_tap_feeder                                                  |
// | Brief    : Tap delay line, double-buffered coefficient bank and decimated  |
// |            valid strobe feeding the adder-tree FIR.                        |
// |            Optional macro FIR_FEEDER_WARMUP_MASK_EN masks valid_out until  |
// |            the delay line is filled with real samples.                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fir_tap_feeder #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int COEFF_WIDTH  = 8,
  parameter int NUM_TAPS     = 37,
  parameter int DECIM        = 1,
  parameter int ADDR_WIDTH   = $clog2(NUM_TAPS)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  fir_tap_feeder_if.slave    bus
);

  localparam int                     PHASE_WIDTH = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PHASE_WIDTH-1:0] PHASE_LAST  = PHASE_WIDTH'(DECIM - 1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } coef_state_t;

  logic                           accept;
  logic                           warm;
  logic signed [SAMPLE_WIDTH-1:0] samples_q [0:NUM_TAPS-1];
  logic signed [SAMPLE_WIDTH-1:0] samples_d [0:NUM_TAPS-1];
  logic signed [COEFF_WIDTH-1:0]  shadow_q  [0:NUM_TAPS-1];
  logic signed [COEFF_WIDTH-1:0]  shadow_d  [0:NUM_TAPS-1];
  logic signed [COEFF_WIDTH-1:0]  active_q  [0:NUM_TAPS-1];
  logic signed [COEFF_WIDTH-1:0]  active_d  [0:NUM_TAPS-1];
  logic [PHASE_WIDTH-1:0]         phase_q, phase_d;
  logic                           valid_out_q, valid_out_d;
  coef_state_t                    state_q, state_d;

  assign bus.s_ready = ~bus.flush;
  assign accept      = bus.s_valid & ~bus.flush;

  always_comb begin
    samples_d = samples_q;
    if (bus.flush) begin
      samples_d = '{default: '0};
    end else if (accept) begin
      samples_d[0] = bus.s_data;
      for (int i = 1; i < NUM_TAPS; i++) begin
        samples_d[i] = samples_q[i-1];
      end
    end
  end

  always_comb begin
    phase_d = phase_q;
    if (bus.flush) begin
      phase_d = '0;
    end else if (accept) begin
      phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
    end
  end

`ifdef FIR_FEEDER_WARMUP_MASK_EN
  localparam int                    FILL_WIDTH = $clog2(NUM_TAPS + 1);
  localparam logic [FILL_WIDTH-1:0] FILL_FULL  = FILL_WIDTH'(NUM_TAPS);
  localparam logic [FILL_WIDTH-1:0] FILL_WARM  = FILL_WIDTH'(NUM_TAPS - 1);

  logic [FILL_WIDTH-1:0] fill_q, fill_d;

  always_comb begin
    fill_d = fill_q;
    if (bus.flush) begin
      fill_d = '0;
    end else if (accept && (fill_q != FILL_FULL)) begin
      fill_d = fill_q + 1'b1;
    end
  end

  // This accept is the NUM_TAPS-th real sample once NUM_TAPS-1 are already held.
  assign warm = (fill_q >= FILL_WARM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end
`else
  assign warm = 1'b1;
`endif

  assign valid_out_d = accept & (phase_q == PHASE_LAST) & warm;

  // Shadow writes are only taken in IDLE so a pending bank cannot change under us;
  // the swap shares the accepting edge with the delay-line shift.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    state_d  = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.coef_we) begin
          for (int k = 0; k < NUM_TAPS; k++) begin
            if (bus.coef_addr == ADDR_WIDTH'(k)) begin
              shadow_d[k] = bus.coef_wdata;
            end
          end
        end
        if (bus.coef_commit) begin
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (accept) begin
          active_d = shadow_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samples_q   <= '{default: '0};
      shadow_q    <= '{default: '0};
      active_q    <= '{default: '0};
      phase_q     <= '0;
      valid_out_q <= 1'b0;
      state_q     <= ST_IDLE;
    end else begin
      samples_q   <= samples_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      phase_q     <= phase_d;
      valid_out_q <= valid_out_d;
      state_q     <= state_d;
    end
  end

  assign bus.samples      = samples_q;
  assign bus.coeffs       = active_q;
  assign bus.valid_out    = valid_out_q;
  assign bus.coef_pending = (state_q == ST_PENDING);

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fir_tap_feeder                                               |
// | Brief    : Scoreboard bench for fir_tap_feeder (DECIM=1 and DECIM=4        |
// |            instances); honours FIR_FEEDER_WARMUP_MASK_EN.                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fir_tap_feeder;

`ifdef FIR_FEEDER_WARMUP_MASK_EN
  localparam bit WARM = 1'b1;
`else
  localparam bit WARM = 1'b0;
`endif

  localparam int N1 = 6;
  localparam int N4 = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_tap_feeder_if #(.SAMPLE_WIDTH(16), .COEFF_WIDTH(8), .NUM_TAPS(N1)) bus1 ();
  fir_tap_feeder_if #(.SAMPLE_WIDTH(16), .COEFF_WIDTH(8), .NUM_TAPS(N4)) bus4 ();

  fir_tap_feeder #(.SAMPLE_WIDTH(16), .COEFF_WIDTH(8), .NUM_TAPS(N1), .DECIM(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));
  fir_tap_feeder #(.SAMPLE_WIDTH(16), .COEFF_WIDTH(8), .NUM_TAPS(N4), .DECIM(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave));

  typedef struct {
    int s0; int s1; int s2; int c0; int c5;
  } exp1_t;

  exp1_t q1[$];
  int    q4[$];
  int    checks  = 0;
  int    errors  = 0;
  int    fill1   = 0;
  int    pulses4 = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus1.valid_out) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_valid", 1, 0);
      end else begin
        exp1_t e;
        e = q1.pop_front();
        chk("dut1_s0", int'(bus1.samples[0]), e.s0);
        chk("dut1_s1", int'(bus1.samples[1]), e.s1);
        chk("dut1_s2", int'(bus1.samples[2]), e.s2);
        chk("dut1_c0", int'(bus1.coeffs[0]),  e.c0);
        chk("dut1_c5", int'(bus1.coeffs[5]),  e.c5);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus4.valid_out) begin
      pulses4++;
      if (q4.size() == 0) begin
        chk("dut4_unexpected_valid", 1, 0);
      end else begin
        int e;
        e = q4.pop_front();
        chk("dut4_s0", int'(bus4.samples[0]), e);
        chk("dut4_s1", int'(bus4.samples[1]), e - 1);
        chk("dut4_s4", int'(bus4.samples[4]), e - 4);
      end
    end
  end

  // One accept on dut1 with the hand-computed taps/coeffs it must present.
  task automatic acc1(input int d, input int e1, input int e2, input int c0, input int c5,
                      input bit commit);
    exp1_t e;
    bus1.s_valid     = 1'b1;
    bus1.s_data      = 16'(d);
    bus1.coef_commit = commit;
    if (fill1 < N1) fill1++;
    if (!WARM || fill1 >= N1) begin
      e.s0 = d; e.s1 = e1; e.s2 = e2; e.c0 = c0; e.c5 = c5;
      q1.push_back(e);
    end
    @(posedge clk); #1;
    bus1.s_valid     = 1'b0;
    bus1.coef_commit = 1'b0;
  endtask

  task automatic wr1(input int addr, input int data, input bit commit);
    bus1.coef_we     = 1'b1;
    bus1.coef_addr   = 3'(addr);
    bus1.coef_wdata  = 8'(data);
    bus1.coef_commit = commit;
    @(posedge clk); #1;
    bus1.coef_we     = 1'b0;
    bus1.coef_commit = 1'b0;
  endtask

  initial begin
    bus1.s_valid = 1'b0; bus1.s_data = '0; bus1.flush = 1'b0; bus1.coef_we = 1'b0;
    bus1.coef_addr = '0; bus1.coef_wdata = '0; bus1.coef_commit = 1'b0;
    bus4.s_valid = 1'b0; bus4.s_data = '0; bus4.flush = 1'b0; bus4.coef_we = 1'b0;
    bus4.coef_addr = '0; bus4.coef_wdata = '0; bus4.coef_commit = 1'b0;

    #12;
    chk("rst_valid_out", int'(bus1.valid_out), 0);
    chk("rst_pending",   int'(bus1.coef_pending), 0);
    chk("rst_sample0",   int'(bus1.samples[0]), 0);
    chk("rst_coeff0",    int'(bus1.coeffs[0]), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_s_ready", int'(bus1.s_ready), 1);

    acc1(1, 0, 0, 0, 0, 1'b0);
    acc1(2, 1, 0, 0, 0, 1'b0);
    acc1(3, 2, 1, 0, 0, 1'b0);
    chk("fill_s3_zero", int'(bus1.samples[3]), 0);
    chk("fill_s5_zero", int'(bus1.samples[5]), 0);
    acc1(4, 3, 2, 0, 0, 1'b0);
    acc1(5, 4, 3, 0, 0, 1'b0);
    acc1(6, 5, 4, 0, 0, 1'b0);

    for (int k = 0; k < 5; k++) wr1(k, k + 1, 1'b0);
    wr1(7, 8'h55, 1'b0);
    wr1(5, 6, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("pend_set",     int'(bus1.coef_pending), 1);
    chk("pend_coeff0",  int'(bus1.coeffs[0]), 0);
    chk("pend_coeff5",  int'(bus1.coeffs[5]), 0);
    wr1(0, 8'h7F, 1'b0);
    acc1(7, 6, 5, 1, 6, 1'b0);
    chk("swap_pending", int'(bus1.coef_pending), 0);
    chk("swap_coeff3",  int'(bus1.coeffs[3]), 4);

    wr1(0, 9, 1'b0);
    acc1(8, 7, 6, 1, 6, 1'b1);
    chk("commit_acc_pending", int'(bus1.coef_pending), 1);
    acc1(9, 8, 7, 9, 6, 1'b0);
    chk("commit_acc_done", int'(bus1.coef_pending), 0);

    bus1.s_valid = 1'b1; bus1.s_data = 16'd99; bus1.flush = 1'b1;
    #1;
    chk("flush_s_ready", int'(bus1.s_ready), 0);
    @(posedge clk); #1;
    bus1.s_valid = 1'b0; bus1.flush = 1'b0;
    fill1 = 0;
    chk("flush_s0", int'(bus1.samples[0]), 0);
    chk("flush_s1", int'(bus1.samples[1]), 0);
    chk("flush_coeff0_kept", int'(bus1.coeffs[0]), 9);
    acc1(100, 0, 0, 9, 6, 1'b0);
    chk("post_flush_s0", int'(bus1.samples[0]), 100);

    wr1(1, 3, 1'b1);
    chk("arst_pre_pending", int'(bus1.coef_pending), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_s0",      int'(bus1.samples[0]), 0);
    chk("arst_coeff0",  int'(bus1.coeffs[0]), 0);
    chk("arst_pending", int'(bus1.coef_pending), 0);
    chk("arst_valid",   int'(bus1.valid_out), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    fill1 = 0;

    for (int n = 1; n <= 12; n++) begin
      bus4.s_valid = 1'b1;
      bus4.s_data  = 16'(n);
      if ((n % 4 == 0) && (!WARM || n >= 8)) q4.push_back(n);
      @(posedge clk); #1;
    end
    bus4.s_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("dut4_pulses", pulses4, WARM ? 2 : 3);
    chk("dut1_queue_drained", q1.size(), 0);
    chk("dut4_queue_drained", q4.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
